// File: rtl/hsi_pixel_reader.sv
// Drains band samples from the spectral-sample FIFO into a valid/ready stream of pixel vectors.
// A 2-entry skid buffer absorbs the FIFO's registered read latency so pops sustain one per cycle.
module hsi_pixel_reader #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned NUM_BANDS = 8,
    parameter int unsigned PIX_W     = 16,
    localparam int unsigned BI_W     = $clog2(NUM_BANDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] num_pixels,
    output logic             busy,
    output logic             done,
    output logic             fifo_rd_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [BI_W-1:0]  m_band_idx,
    output logic             m_last_band,
    output logic             m_last_pixel
);

    localparam int unsigned CNT_W = PIX_W + BI_W + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] num_pixels_q, num_pixels_d;
    logic [CNT_W-1:0] reads_left_q, reads_left_d;
    logic             inflight_q;
    logic [WIDTH-1:0] buf_mem_q [2];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
    logic [BI_W-1:0]  band_idx_q, band_idx_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;

    logic             start_acc;
    logic             pop;
    logic             push;
    logic             band_wrap;
    logic             last_beat;
    logic [2:0]       occ;
    logic [PIX_W-1:0] last_pix;

    assign start_acc = start && (state_q == StIdle);
    assign pop       = m_valid && m_ready;
    assign push      = inflight_q;

    // Occupancy after this cycle, counting the word already requested from the FIFO.
    assign occ = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign fifo_rd_en = (state_q == StRun) && !fifo_empty && (reads_left_q != '0)
                        && (occ < 3'd2);

    assign last_pix  = num_pixels_q - PIX_W'(1);
    assign band_wrap = (band_idx_q == BI_W'(NUM_BANDS - 1));

    assign m_valid      = (buf_cnt_q != 2'd0);
    assign m_data       = buf_mem_q[rd_ptr_q];
    assign m_band_idx   = band_idx_q;
    assign m_last_band  = band_wrap;
    assign m_last_pixel = (pix_idx_q == last_pix);
    assign last_beat    = pop && m_last_band && m_last_pixel;

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

    always_comb begin
        state_d      = state_q;
        num_pixels_d = num_pixels_q;
        reads_left_d = reads_left_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    num_pixels_d = num_pixels;
                    reads_left_d = CNT_W'(num_pixels) * CNT_W'(NUM_BANDS);
                    state_d      = (num_pixels == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (fifo_rd_en) begin
                    reads_left_d = reads_left_q - CNT_W'(1);
                end
                if (last_beat) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        band_idx_d = band_idx_q;
        pix_idx_d  = pix_idx_q;
        if (start_acc) begin
            band_idx_d = '0;
            pix_idx_d  = '0;
        end else if (pop) begin
            if (band_wrap) begin
                band_idx_d = '0;
                pix_idx_d  = pix_idx_q + PIX_W'(1);
            end else begin
                band_idx_d = band_idx_q + BI_W'(1);
            end
        end
    end

    always_comb begin
        buf_cnt_d = buf_cnt_q;
        if (push && !pop) begin
            buf_cnt_d = buf_cnt_q + 2'd1;
        end else if (pop && !push) begin
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            num_pixels_q <= '0;
            reads_left_q <= '0;
            band_idx_q   <= '0;
            pix_idx_q    <= '0;
        end else begin
            state_q      <= state_d;
            num_pixels_q <= num_pixels_d;
            reads_left_q <= reads_left_d;
            band_idx_q   <= band_idx_d;
            pix_idx_q    <= pix_idx_d;
        end
    end

    // Words still in flight at reset are dropped; the FIFO itself is not touched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            buf_mem_q[0] <= '0;
            buf_mem_q[1] <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_cnt_q    <= 2'd0;
        end else begin
            inflight_q <= fifo_rd_en;
            if (push) begin
                buf_mem_q[wr_ptr_q] <= fifo_data;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            buf_cnt_q <= buf_cnt_d;
        end
    end

endmodule

// File: doc/hsi_pixel_reader.md
# hsi_pixel_reader

Drain stage directly downstream of the spectral-sample cache FIFO: pops band samples from the FIFO, groups them into pixel vectors of `NUM_BANDS` samples, and presents them as a valid/ready stream to the HSI processing core. It hides the FIFO's 1-cycle registered read latency behind a 2-entry output buffer, so it sustains one sample per cycle under backpressure. It also tracks band and pixel position for the frame and signals completion.

## Interface
- `WIDTH`, 16: sample width in bits; must match the FIFO width.
- `NUM_BANDS`, 8: samples per pixel; ≥2.
- `PIX_W`, 16: width of the pixel count.
- `BI_W`: `$clog2(NUM_BANDS)`. Local only, not overridable.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle frame start pulse; ignored unless IDLE.
- `num_pixels`  in  PIX_W: pixels in the frame; sampled at the accepted `start`.
- `busy`  out  1: high whenever the state is not IDLE.
- `done`  out  1: one-cycle pulse at frame end.
- `fifo_rd_en`  out  1: FIFO pop request.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_data`  in  WIDTH: FIFO registered read data; valid the cycle after a pop.
- `m_valid`  out  1: output sample valid.
- `m_ready`  in  1: downstream ready.
- `m_data`  out  WIDTH: sample value.
- `m_band_idx`  out  BI_W: band index of the sample, 0..NUM_BANDS-1.
- `m_last_band`  out  1: sample is the last band of its pixel.
- `m_last_pixel`  out  1: sample belongs to the last pixel of the frame.

## Operation
- **States:** IDLE, RUN, DONE.
  - IDLE→RUN on `start`. The block latches `num_pixels` and loads the read counter with `num_pixels*NUM_BANDS`. The product uses PIX_W+BI_W+1 bits; it does not wrap.
  - IDLE→DONE on `start` when `num_pixels==0`. No reads are issued.
  - RUN→DONE on the output handshake where `m_last_band && m_last_pixel`.
  - DONE→IDLE unconditionally after one cycle. `done` is high only in DONE.
- **Pop rule (combinational):** `fifo_rd_en = RUN && !fifo_empty && reads_left>0 && (buf_cnt + inflight - pop) < 2`, where `pop = m_valid && m_ready`.
  - `fifo_rd_en` is never asserted while `fifo_empty=1`.
- **Data capture:** `inflight` is a 1-bit register equal to `fifo_rd_en` of the previous cycle. When `inflight=1`, `fifo_data` is written into the 2-entry buffer at the end of that cycle. Overflow is impossible by the pop rule.
- **Output:** the buffer head drives `m_data`. `m_valid = (buf_cnt != 0)`. Push and pop in the same cycle leave `buf_cnt` unchanged.
- **Position counters:** both advance only on `pop`.
  - `band_idx` wraps from NUM_BANDS-1 to 0.
  - `pix_idx` increments when `band_idx` wraps.
  - `m_band_idx = band_idx`.
  - `m_last_band = (band_idx == NUM_BANDS-1)`.
  - `m_last_pixel = (pix_idx == num_pixels_q - 1)`.
- **Counter reset:** both counters clear on accepted `start`.
- **start while busy:** no effect.
- **Backpressure:** while `m_valid && !m_ready`, `m_data` and all `m_*` outputs hold stable.
- **Reset mid-frame:** immediate return to IDLE. Buffer and counters are cleared. Samples already popped are discarded. Remaining FIFO contents are left untouched.

## Timing
- **Reset values:** every output is 0 (`busy`, `done`, `fifo_rd_en`, `m_valid`, `m_data`, `m_band_idx`, `m_last_band`, `m_last_pixel`). State is IDLE.
- **Latency:** with `start` in cycle 0, `busy` rises in cycle 1. The first `fifo_rd_en` is in cycle 1 if the FIFO is non-empty. Data arrives in cycle 2. `m_valid` rises in cycle 3. In general, pop in cycle t gives `m_valid` in cycle t+2.
- **Throughput:** one sample per cycle with the FIFO non-empty and `m_ready=1`.
- **Completion:** `done` and the state DONE occur in the cycle after the final handshake. `busy` is still high in that cycle and low in the following cycle.
- **Zero-pixel frame:** `done` in cycle 1 and `busy` high only in cycle 1.

## Test plan
1. Assert `rst` asynchronously mid-cycle, idle inputs -> all outputs 0 immediately; `fifo_rd_en` stays 0 while `rst=1`.
2. NUM_BANDS=8, `num_pixels=2`, FIFO prefilled with 0..15, `m_ready=1`, `start` at cycle 0 -> `fifo_rd_en` high cycles 1-16. Beats 0..15 occur in cycles 3-18. `m_band_idx` runs 0..7 twice. `m_last_band` is set on beats 7 and 15. `m_last_pixel` is set on beats 8-15. `done` pulses in cycle 19.
3. Same frame with `m_ready` pseudo-random at 50% -> output sequence identical to scenario 2 with no drop or duplicate. Outputs stable while stalled. `buf_cnt + inflight` never exceeds 2.
4. FIFO fed 1 word every 3 cycles -> `fifo_rd_en` never asserted with `fifo_empty=1`. All 16 samples delivered in order; `done` after the last one.
5. `num_pixels=0` -> `done` in cycle 1, zero pops. A second `start` pulsed mid-run in scenario 2 -> ignored; the frame completes unchanged.
6. `rst` pulsed after beat 5 of scenario 2 -> outputs 0 and state IDLE. A fresh `start` with `num_pixels=1` then delivers the next 8 FIFO words with `m_band_idx` 0..7.
